mux_probe_sequencer: RTL and testbench
======================================

Name: mux_probe_sequencer

Overview:
- Self-test sequencer for the 2:1 mux probe stage.
- Drives S/I0/I1 through all 8 input vectors and samples the 9-bit probe bus that the mux stage returns.
- Compares each sample against the expected probe function and reports pass/fail, error count and first failing vector.
- Sits directly around the mux stage: its outputs feed the mux inputs, and the mux output bus feeds `probe`.

Parameters:
- SETTLE_CYCLES, 2: clocks between applying a vector and sampling `probe`. Legal range 1..15.
- CNT_W, 4: width of `err_count`. Must hold the value 8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a sweep when idle
- S  out  1  mux select drive (registered)
- I0  out  1  mux data-0 drive (registered)
- I1  out  1  mux data-1 drive (registered)
- probe  in  9  mux probe bus from the stage under test
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  high after a sweep with zero mismatches; held until next start
- err_count  out  CNT_W  mismatches in the last/current sweep
- first_fail  out  3  vector index {S,I1,I0} of the first mismatch; 0 if none
- fail_probe  out  9  captured probe of the first mismatch (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0) clears everything immediately:
  - S=I0=I1=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_probe=0.
  - FSM goes to IDLE and vector index idx=0.
- Vector index: idx is 3 bits, idx = {S,I1,I0}. It is swept 0,1,...,7 in order.
- Expected probe for a vector:
  - bit0=I0, bit1=I1, bit2=S, bit3=S, bit4=S, bit5=~S, bit6=I1&S, bit7=1, bit8=1.
  - Example: idx 0 -> 9'h1A0; idx 7 -> 9'h1DF.
- FSM states:
  - IDLE: busy=0. When start=1: clear err_count, first_fail, fail_probe and pass; set idx=0; go to APPLY.
  - APPLY (1 cycle): register {S,I1,I0}<=idx; busy=1; load settle counter=SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter each clock; go to CHECK when the count reaches 1.
  - CHECK (1 cycle): compare `probe` with the expected value for idx.
    - On mismatch: err_count+=1. If this is the first mismatch, latch first_fail=idx (and fail_probe).
    - If idx==7 go to DONE; otherwise idx+=1 and go to APPLY.
  - DONE (1 cycle): done=1; pass=(err_count==0); busy=0; go to IDLE.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 clocks.
  - A full sweep takes 8*(SETTLE_CYCLES+2)+1 clocks from start-accept to the done pulse: 33 at default.
- Boundary conditions:
  - start while busy: ignored. No restart, no counter clear.
  - start in the same cycle as DONE: ignored. It is accepted only in IDLE.
  - idx wrap 7->0: never occurs within a sweep. The sweep ends at 7.
  - err_count: maximum value is 8, so no overflow at CNT_W>=4.
  - The first mismatch at idx 0 gives first_fail=0. Distinguish it from "no fail" using err_count!=0.
  - Reset mid-sweep: immediate abort. All outputs return to reset values. No done pulse.
- Output drive: S/I0/I1 hold their last vector after a sweep until the next APPLY.

Optional Feature:
- Macro MUX_PROBE_CAPTURE_EN.
- Defined: fail_probe is a 9-bit register. It latches the raw `probe` value at the first mismatch and holds it until the next accepted start or reset.
- Undefined: fail_probe is tied to 9'h000 and no capture register is built. All other behaviour is identical.

Test Plan:
- Good mux model, start pulse -> busy=1 for 32 cycles, done pulse at cycle 33, pass=1, err_count=0, first_fail=0.
- Model with probe bit6 stuck-at-0 -> mismatches only at idx 6,7 -> err_count=2, first_fail=6, pass=0. With macro, fail_probe=9'h19E.
- Model with bit7 stuck-at-0 -> all 8 vectors fail -> err_count=8, first_fail=0, pass=0.
- Assert rst_n=0 during the SETTLE of idx 4 -> all outputs 0 immediately. After release, no done pulse; a new start gives a clean 33-cycle sweep.
- Pulse start again at cycle 10 of a sweep -> ignored; sweep completes at original cycle 33 with unchanged counts.
- SETTLE_CYCLES=5 with a probe model of 4-cycle delay -> pass=1; done pulse 8*7+1=57 cycles after start.

Source files
------------

// File: rtl/mux_probe_sequencer_if.sv
// Drive/return bus between the self-test sequencer and the 2:1 mux probe stage.
// The sequencer drives S/I0/I1; the stage returns its 9-bit probe bus.
interface mux_probe_sequencer_if;
    logic       S;
    logic       I0;
    logic       I1;
    logic [8:0] probe;

    modport master (output S, output I0, output I1, input probe);
    modport slave  (input S, input I0, input I1, output probe);
endinterface

// File: rtl/mux_probe_sequencer.sv
// Self-test sequencer: sweeps {S,I1,I0} over all 8 vectors and checks the returned probe bus.
// Optional macro MUX_PROBE_CAPTURE_EN builds a register that captures the probe of the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last sweep's results
// APPLY  | register the current vector onto S/I1/I0
// SETTLE | wait SETTLE_CYCLES clocks for the stage under test to respond
// CHECK  | compare probe with the expected function, advance or finish
// DONE   | one-cycle done pulse with final pass flag
module mux_probe_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    mux_probe_sequencer_if.master   mux,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_count,
    output logic [2:0]              first_fail,
    output logic [8:0]              fail_probe
);

    typedef enum logic [2:0] {ST_IDLE, ST_APPLY, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       drv_q, drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [2:0]       ff_q, ff_d;
    logic             mismatch;

    function automatic logic [8:0] expected_probe(input logic [2:0] v);
        logic s, i1, i0;
        s  = v[2];
        i1 = v[1];
        i0 = v[0];
        return {1'b1, 1'b1, i1 & s, ~s, s, s, s, i1, i0};
    endfunction

    assign mismatch = (mux.probe != expected_probe(idx_q));

`ifdef MUX_PROBE_CAPTURE_EN
    logic [8:0] cap_q, cap_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
`ifdef MUX_PROBE_CAPTURE_EN
        cap_d   = cap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    ff_d    = 3'd0;
                    pass_d  = 1'b0;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_APPLY;
`ifdef MUX_PROBE_CAPTURE_EN
                    cap_d   = 9'h000;
`endif
                end
            end
            ST_APPLY: begin
                drv_d   = idx_q;
                cnt_d   = SETTLE_LD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + CNT_W'(1);
                    if (err_q == '0) begin
                        ff_d = idx_q;
`ifdef MUX_PROBE_CAPTURE_EN
                        cap_d = mux.probe;
`endif
                    end
                end
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = !mismatch && (err_q == '0);
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            drv_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

`ifdef MUX_PROBE_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap_q <= 9'h000;
        else        cap_q <= cap_d;
    end
    assign fail_probe = cap_q;
`else
    assign fail_probe = 9'h000;
`endif

    // drv_q is {S,I1,I0}, matching the vector index layout
    assign mux.S      = drv_q[2];
    assign mux.I1     = drv_q[1];
    assign mux.I0     = drv_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_mux_probe_sequencer.sv
// Bench for mux_probe_sequencer: two instances (settle 2 with a combinational stage,
// settle 5 with a 4-cycle delayed stage), stuck-at fault models and a sweep-level reference.
module tb_mux_probe_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_w [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       pass_w  [2];
    logic [3:0] err_w   [2];
    logic [2:0] ff_w    [2];
    logic [8:0] fp_w    [2];
    logic [8:0] sa0     [2];
    logic [8:0] sa1     [2];
    logic [8:0] pipe1   [4];

    int checks;
    int failures;

    mux_probe_sequencer_if if0 ();
    mux_probe_sequencer_if if1 ();

    mux_probe_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .mux(if0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_fail(ff_w[0]), .fail_probe(fp_w[0]));

    mux_probe_sequencer #(.SETTLE_CYCLES(5), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .mux(if1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_fail(ff_w[1]), .fail_probe(fp_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Probe function written from the bit list as plain arithmetic on the vector index
    function automatic logic [8:0] good_probe(input int v);
        int s, i1, i0;
        s  = (v >> 2) & 1;
        i1 = (v >> 1) & 1;
        i0 = v & 1;
        return 9'(256 + 128 + 64 * (i1 * s) + 32 * (1 - s) + 28 * s + 2 * i1 + i0);
    endfunction

    function automatic logic [8:0] faulty(input int v, input logic [8:0] a0, input logic [8:0] a1);
        return (good_probe(v) & ~a0) | a1;
    endfunction

    always_comb if0.probe = faulty(4 * int'(if0.S) + 2 * int'(if0.I1) + int'(if0.I0), sa0[0], sa1[0]);

    always_ff @(posedge clk) begin
        pipe1[0] <= faulty(4 * int'(if1.S) + 2 * int'(if1.I1) + int'(if1.I0), sa0[1], sa1[1]);
        for (int k = 1; k < 4; k++) pipe1[k] <= pipe1[k-1];
    end
    assign if1.probe = pipe1[3];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input int u, input string tag);
        check_eq({tag, "_busy"}, busy_w[u], 0);
        check_eq({tag, "_done"}, done_w[u], 0);
        check_eq({tag, "_pass"}, pass_w[u], 0);
        check_eq({tag, "_err"},  err_w[u],  0);
        check_eq({tag, "_ff"},   ff_w[u],   0);
        check_eq({tag, "_fp"},   fp_w[u],   0);
        if (u == 0) check_eq({tag, "_drv"}, {if0.S, if0.I1, if0.I0}, 0);
        else        check_eq({tag, "_drv"}, {if1.S, if1.I1, if1.I0}, 0);
    endtask

    task automatic run_sweep(input int u, input logic [8:0] a0, input logic [8:0] a1,
                             input bit poke, input int abort_at);
        int settle, exp_err, exp_ff, cyc, busy_cnt, seen_done;
        logic [8:0] exp_fp;
        settle  = (u == 0) ? 2 : 5;
        sa0[u]  = a0;
        sa1[u]  = a1;
        exp_err = 0;
        exp_ff  = 0;
        exp_fp  = 9'h000;
        for (int v = 0; v < 8; v++) begin
            if (faulty(v, a0, a1) != good_probe(v)) begin
                if (exp_err == 0) begin
                    exp_ff = v;
                    exp_fp = faulty(v, a0, a1);
                end
                exp_err++;
            end
        end
`ifndef MUX_PROBE_CAPTURE_EN
        exp_fp = 9'h000;
`endif
        @(negedge clk);
        start_w[u] = 1'b1;
        @(negedge clk);
        start_w[u] = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done_w[u] && cyc < 300) begin
            if (abort_at == cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero(u, "abort");
                @(negedge clk);
                rst_n = 1'b1;
                seen_done = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (done_w[u] || busy_w[u]) seen_done = 1;
                end
                check_eq("abort_no_done", seen_done, 0);
                return;
            end
            if (busy_w[u]) busy_cnt++;
            start_w[u] = poke && (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        start_w[u] = 1'b0;
        check_eq("latency", cyc, 8 * (settle + 2) + 1);
        check_eq("busy_cycles", busy_cnt, 8 * (settle + 2));
        check_eq("done_busy", busy_w[u], 0);
        check_eq("pass", pass_w[u], (exp_err == 0) ? 1 : 0);
        check_eq("err_count", err_w[u], exp_err);
        check_eq("first_fail", ff_w[u], exp_ff);
        check_eq("fail_probe", fp_w[u], exp_fp);
        if (u == 0) check_eq("drv_hold", {if0.S, if0.I1, if0.I0}, 7);
        else        check_eq("drv_hold", {if1.S, if1.I1, if1.I0}, 7);
        // start during DONE must be ignored
        start_w[u] = 1'b1;
        @(negedge clk);
        start_w[u] = 1'b0;
        check_eq("done_pulse_width", done_w[u], 0);
        check_eq("start_in_done_ignored", busy_w[u], 0);
        check_eq("pass_held", pass_w[u], (exp_err == 0) ? 1 : 0);
        check_eq("err_held", err_w[u], exp_err);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_w[u] = 1'b0;
            sa0[u]     = 9'h000;
            sa1[u]     = 9'h000;
        end
        repeat (3) @(negedge clk);
        check_all_zero(0, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 9'h000, 9'h000, 1'b0, 0);
        run_sweep(0, 9'h040, 9'h000, 1'b1, 0);
        run_sweep(0, 9'h080, 9'h000, 1'b0, 0);
        run_sweep(0, 9'h080, 9'h000, 1'b0, 18);
        run_sweep(0, 9'h000, 9'h000, 1'b0, 0);
        run_sweep(1, 9'h000, 9'h000, 1'b0, 0);

        for (int n = 0; n < 8; n++) begin
            logic [8:0] r0, r1;
            r0 = 9'($urandom & $urandom & $urandom);
            r1 = 9'($urandom & $urandom & $urandom) & ~r0;
            run_sweep(0, r0, r1, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
